rgbw_pwm: RTL and testbench

- 4-channel PWM output stage directly downstream of the colour generator.
- Consumes the generator's 8-bit red/green/blue/white levels and drives the LED driver pins.
- Duty values are double-buffered: a load captures them into shadow registers, and they are applied only at a PWM period boundary, so outputs never glitch mid-period.
- A programmable prescaler sets the PWM frequency.

---
 rtl/rgbw_pkg.sv | 20 ++
 rtl/rgbw_pwm_channel.sv | 62 ++++++
 rtl/rgbw_pwm.sv | 87 ++++++++
 tb/tb_rgbw_pwm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_pkg.sv
// rgbw_pkg: shared constants and types for the RGBW PWM output stage.
//   PWM_PERIOD   - ticks per PWM period (counter runs 0..PWM_MAX_CNT)
//   PWM_MAX_CNT  - last counter value before the wrap to 0
//   STAGGER_STEP - per-channel phase offset in ticks (PHASE_STAGGER_EN builds)
//   CH_*         - channel indices (red, green, blue, white)
//   duty_t       - 8-bit duty / counter value
package rgbw_pkg;

  localparam int unsigned PWM_PERIOD   = 255;
  localparam int unsigned PWM_MAX_CNT  = 254;
  localparam int unsigned STAGGER_STEP = 64;

  localparam int unsigned CH_RED   = 0;
  localparam int unsigned CH_GREEN = 1;
  localparam int unsigned CH_BLUE  = 2;
  localparam int unsigned CH_WHITE = 3;

  typedef logic [7:0] duty_t;

endpackage

// File: rtl/rgbw_pwm_channel.sv
// pwm_channel: one PWM channel with a double-buffered duty.
// Optional build macro: PHASE_STAGGER_EN (channel compares against a
// counter offset by STAGGER_STEP*CH, wrapped modulo PWM_PERIOD).
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   load   in  capture din into the shadow duty
//   apply  in  copy shadow into the active duty (period boundary)
//   din    in  new duty value
//   cnt    in  shared PWM counter (0..PWM_MAX_CNT)
//   pwm    out registered PWM output, high while offset count < active duty
module pwm_channel
  import rgbw_pkg::*;
#(
  parameter int unsigned CH = 0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  apply,
  input  duty_t din,
  input  duty_t cnt,
  output logic  pwm
);

`ifdef PHASE_STAGGER_EN
  localparam int unsigned OFFSET = STAGGER_STEP * CH;
`else
  localparam int unsigned OFFSET = 0;
`endif

  duty_t      shadow;
  duty_t      active;
  duty_t      ck;
  logic [8:0] sum;

  // Offset count stays within 0..PWM_MAX_CNT, so every duty keeps the
  // same high time per period whatever the offset.
  always_comb begin
    sum = {1'b0, cnt} + 9'(OFFSET);
    if (sum >= 9'(PWM_PERIOD)) begin
      ck = 8'(sum - 9'(PWM_PERIOD));
    end else begin
      ck = sum[7:0];
    end
  end

  // apply reads the pre-edge shadow, so a load in the same cycle is
  // held back for the following period boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (apply) active <= shadow;
      if (load)  shadow <= din;
      pwm <= (ck < active);
    end
  end

endmodule

// File: rtl/rgbw_pwm.sv
// rgbw_pwm: 4-channel PWM output stage for the colour generator.
// Optional build macro: PHASE_STAGGER_EN (staggers channel rising edges by
// STAGGER_STEP ticks; see pwm_channel).
// Ports:
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   presc      in  [PRESC_W] prescaler; a counter tick every presc+1 clocks
//   load       in  strobe capturing redIn/greenIn/blueIn/whiteIn into shadow
//   redIn..whiteIn in [8] duty values (0 = off, 255 = always on)
//   pwmRed..pwmWhite out PWM pins
//   pending    out shadow holds values not yet applied
//   applied    out one-cycle pulse when shadow is copied to active
//   periodEnd  out one-cycle pulse when the counter wraps 254 -> 0
module rgbw_pwm
  import rgbw_pkg::*;
#(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] presc,
  input  logic               load,
  input  logic [7:0]         redIn,
  input  logic [7:0]         greenIn,
  input  logic [7:0]         blueIn,
  input  logic [7:0]         whiteIn,
  output logic               pwmRed,
  output logic               pwmGreen,
  output logic               pwmBlue,
  output logic               pwmWhite,
  output logic               pending,
  output logic               applied,
  output logic               periodEnd
);

  logic [PRESC_W-1:0] pcnt;
  duty_t              cnt;
  logic               tick;
  logic               wrap;
  logic               apply;

  // >= rather than == so lowering presc mid-count ticks immediately.
  assign tick  = (pcnt >= presc);
  assign wrap  = tick && (cnt == 8'(PWM_MAX_CNT));
  assign apply = wrap && pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt      <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      applied   <= 1'b0;
      periodEnd <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) cnt <= wrap ? '0 : cnt + 8'd1;
      if (load) begin
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
      applied   <= apply;
      periodEnd <= wrap;
    end
  end

  pwm_channel #(.CH(CH_RED)) u_red (
    .clk(clk), .reset(reset), .load(load), .apply(apply),
    .din(redIn), .cnt(cnt), .pwm(pwmRed)
  );

  pwm_channel #(.CH(CH_GREEN)) u_green (
    .clk(clk), .reset(reset), .load(load), .apply(apply),
    .din(greenIn), .cnt(cnt), .pwm(pwmGreen)
  );

  pwm_channel #(.CH(CH_BLUE)) u_blue (
    .clk(clk), .reset(reset), .load(load), .apply(apply),
    .din(blueIn), .cnt(cnt), .pwm(pwmBlue)
  );

  pwm_channel #(.CH(CH_WHITE)) u_white (
    .clk(clk), .reset(reset), .load(load), .apply(apply),
    .din(whiteIn), .cnt(cnt), .pwm(pwmWhite)
  );

endmodule

// File: tb/tb_rgbw_pwm.sv
// tb_rgbw_pwm: self-checking bench for rgbw_pwm. A cycle model pushes the
// expected output vector at each rising edge; it is popped and compared on
// the following falling edge. Directed checks cover timing properties.
module tb_rgbw_pwm;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] presc;
  logic       load;
  logic [7:0] redIn, greenIn, blueIn, whiteIn;
  logic       pwmRed, pwmGreen, pwmBlue, pwmWhite;
  logic       pending, applied, periodEnd;

  int n_vec = 0;
  int n_err = 0;

  rgbw_pwm #(.PRESC_W(8)) dut (
    .clk(clk), .reset(reset), .presc(presc), .load(load),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn), .whiteIn(whiteIn),
    .pwmRed(pwmRed), .pwmGreen(pwmGreen), .pwmBlue(pwmBlue),
    .pwmWhite(pwmWhite), .pending(pending), .applied(applied),
    .periodEnd(periodEnd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pcnt = 0;
  int m_cnt  = 0;
  int m_sh[4];
  int m_act[4];
  bit m_pend = 0;
  logic [6:0] sb_q[$];

  function automatic int offs(input int k);
`ifdef PHASE_STAGGER_EN
    return 64 * k;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    int din[4];
    logic [3:0] pw;
    bit tk, wr, ap;
    din = '{int'(redIn), int'(greenIn), int'(blueIn), int'(whiteIn)};
    if (reset) begin
      m_pcnt = 0; m_cnt = 0; m_pend = 0;
      for (int k = 0; k < 4; k++) begin m_sh[k] = 0; m_act[k] = 0; end
      sb_q.push_back(7'b0);
    end else begin
      for (int k = 0; k < 4; k++) pw[k] = (((m_cnt + offs(k)) % 255) < m_act[k]);
      tk = (m_pcnt >= int'(presc));
      wr = tk && (m_cnt == 254);
      ap = wr && m_pend;
      if (ap) for (int k = 0; k < 4; k++) m_act[k] = m_sh[k];
      if (load) for (int k = 0; k < 4; k++) m_sh[k] = din[k];
      if (load) m_pend = 1; else if (wr) m_pend = 0;
      m_pcnt = tk ? 0 : m_pcnt + 1;
      if (tk) m_cnt = wr ? 0 : m_cnt + 1;
      sb_q.push_back({pw[3], pw[2], pw[1], pw[0], m_pend, ap, wr});
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      check("outputs", {25'b0, pwmWhite, pwmBlue, pwmGreen, pwmRed,
                        pending, applied, periodEnd}, {25'b0, sb_q.pop_front()});
    end
  end

  // ---------------- stimulus helpers ----------------
  // sel 0 waits for periodEnd, sel 1 for applied; ends on a falling edge.
  task automatic wait_sig(input int sel, input int limit, input string tag);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = (sel == 0) ? periodEnd : applied;
    end
    check(tag, {31'b0, seen}, 1);
  endtask

  task automatic do_load(input logic [7:0] r, g, b, w);
    redIn = r; greenIn = g; blueIn = b; whiteIn = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int n, hr, hg, hb, hw, found;
    int rise[4];
    int hi[4];
    logic [3:0] prev, cur;

    reset = 1'b1; presc = 8'd0; load = 1'b0;
    redIn = '0; greenIn = '0; blueIn = '0; whiteIn = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm", {28'b0, pwmWhite, pwmBlue, pwmGreen, pwmRed}, 0);
    check("reset_flags", {29'b0, pending, applied, periodEnd}, 0);
    reset = 1'b0;

    // Idle: periodEnd every 255 clocks, nothing pending.
    wait_sig(0, 300, "idle_first_pe");
    n = 0;
    do begin @(negedge clk); n++; end while (!periodEnd && n < 400);
    check("idle_pe_interval", n, 255);
    check("idle_pending", {31'b0, pending}, 0);

    // Red 128: pending until the wrap, then 128 high / 127 low.
    do_load(8'd128, 8'd0, 8'd0, 8'd0);
    check("red_pending", {31'b0, pending}, 1);
    wait_sig(1, 300, "red_applied");
    hr = 0;
    repeat (255) begin @(negedge clk); hr += int'(pwmRed); end
    check("red_high_128", hr, 128);

    // Duty 0 / 255 extremes across a wrap.
    do_load(8'd128, 8'd0, 8'd255, 8'd0);
    wait_sig(1, 300, "ext_applied");
    hg = 0; hb = 0;
    repeat (300) begin @(negedge clk); hg += int'(pwmGreen); hb += int'(pwmBlue); end
    check("green_duty0", hg, 0);
    check("blue_duty255", hb, 300);

    // Load landing exactly on the wrap cycle.
    wait_sig(0, 300, "wl_sync_pe");
    do_load(8'd10, 8'd0, 8'd255, 8'd0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_cnt == 254) found = 1; else @(negedge clk);
    end
    check("wl_found_254", found, 1);
    do_load(8'd200, 8'd0, 8'd255, 8'd0);
    check("wl_applied", {31'b0, applied}, 1);
    check("wl_pending_kept", {31'b0, pending}, 1);
    hr = 0;
    repeat (255) begin @(negedge clk); hr += int'(pwmRed); end
    check("wl_red_10", hr, 10);
    check("wl_applied2", {31'b0, applied}, 1);
    check("wl_pending_clr", {31'b0, pending}, 0);
    hr = 0;
    repeat (255) begin @(negedge clk); hr += int'(pwmRed); end
    check("wl_red_200", hr, 200);

    // presc = 3: period 1020 clocks; lowering presc ticks at once.
    presc = 8'd3;
    do_load(8'd0, 8'd0, 8'd0, 8'd255);
    wait_sig(1, 1100, "p3_applied");
    n = 0;
    do begin @(negedge clk); n++; end while (!periodEnd && n < 1100);
    check("p3_pe_interval", n, 1020);
    hw = 0;
    repeat (1020) begin @(negedge clk); hw += int'(pwmWhite); end
    check("p3_white_on", hw, 1020);
    found = 0;
    for (int i = 0; i < 1100 && !found; i++) begin
      if (m_cnt == 254 && m_pcnt == 2) found = 1; else @(negedge clk);
    end
    check("p3_found_pcnt2", found, 1);
    presc = 8'd1;
    @(negedge clk);
    check("presc_drop_tick", {31'b0, periodEnd}, 1);
    presc = 8'd0;

    // Reset in mid-period forces outputs low.
    repeat (37) @(negedge clk);
    check("pre_rst_white", {31'b0, pwmWhite}, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm", {28'b0, pwmWhite, pwmBlue, pwmGreen, pwmRed}, 0);
    check("rst_mid_flags", {29'b0, pending, applied, periodEnd}, 0);
    reset = 1'b0;

    // All duties 64: rise positions and high time per channel. A channel
    // rises where cnt + offset wraps to 0, i.e. cnt = (255 - offset) % 255.
    do_load(8'd64, 8'd64, 8'd64, 8'd64);
    wait_sig(1, 300, "st_applied");
    prev = {pwmWhite, pwmBlue, pwmGreen, pwmRed};
    for (int k = 0; k < 4; k++) begin rise[k] = -1; hi[k] = 0; end
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      cur = {pwmWhite, pwmBlue, pwmGreen, pwmRed};
      for (int k = 0; k < 4; k++) begin
        if (cur[k] && !prev[k] && rise[k] < 0) rise[k] = i;
        if (i <= 255) hi[k] += int'(cur[k]);
      end
      prev = cur;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("st_high_%0d", k), hi[k], 64);
      check($sformatf("st_rise_%0d", k),
            (rise[k] < 0 || rise[0] < 0) ? -1 : (rise[k] - rise[0] + 255) % 255,
            (255 - offs(k)) % 255);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
